mem_flash_responder: RTL and testbench



---
 rtl/mem_flash_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_flash_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_flash_responder.sv
// SPI/QSPI NOR flash responder: oversamples sclk on clk, out_io/io_oe update 1 clk after a detected sclk fall; no backpressure.
// Optional quad output fast read (opcode 0x6B) is built only when FLASH_MODEL_QUAD_EN is defined.
module mem_flash_responder #(
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic [3:0] in_io,
  output logic [3:0] out_io,
  output logic [3:0] io_oe,
  output logic       wel,
  output logic [7:0] last_cmd
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(8'hFF);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_STATUS, S_IGNORE
  } state_t;

  logic       cs_s1_q, cs_s2_q, cs_s3_q;
  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic [3:0] io_s1_q, io_s2_q;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wel_q, wel_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic [3:0]        out_io_q, out_io_d;
  logic [3:0]        io_oe_q, io_oe_d;
  logic              pp_q, pp_d;
  logic              quad_q, quad_d;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_rd_q;
  logic       wr_en;
  logic [7:0] rx_byte;
  logic       rise, fall, cs_rise, cs_fall;
  logic       unused_io;

  // Edges are only honoured while the synchronized chip select is asserted.
  assign rise    = sclk_s2_q & ~sclk_s3_q & ~cs_s2_q;
  assign fall    = ~sclk_s2_q & sclk_s3_q & ~cs_s2_q;
  assign cs_rise = cs_s2_q & ~cs_s3_q;
  assign cs_fall = ~cs_s2_q & cs_s3_q;
  assign rx_byte = {sh_q[6:0], io_s2_q[0]};
  assign unused_io = ^io_s2_q[3:1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    wel_d      = wel_q;
    last_cmd_d = last_cmd_q;
    out_io_d   = out_io_q;
    io_oe_d    = io_oe_q;
    pp_d       = pp_q;
    quad_d     = quad_q;
    wr_en      = 1'b0;

    if (cs_rise) begin
      state_d  = S_IDLE;
      cnt_d    = 5'd0;
      sh_d     = 8'h00;
      out_io_d = 4'h0;
      io_oe_d  = 4'h0;
      pp_d     = 1'b0;
      quad_d   = 1'b0;
      if (pp_q) wel_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = 5'd0;
          end
        end
        S_CMD: begin
          if (rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d      = 5'd0;
              last_cmd_d = rx_byte;
              state_d    = S_IGNORE;
              case (rx_byte)
                8'h06: wel_d = 1'b1;
                8'h04: wel_d = 1'b0;
                8'h05: begin
                  state_d = S_STATUS;
                  tx_d    = {6'b0, wel_q, 1'b0};
                end
                8'h03: state_d = S_ADDR;
                8'h02: begin
                  if (wel_q) begin
                    state_d = S_ADDR;
                    pp_d    = 1'b1;
                  end
                end
`ifdef FLASH_MODEL_QUAD_EN
                8'h6B: begin
                  state_d = S_ADDR;
                  quad_d  = 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_d = {addr_q[ADDR_W-2:0], io_s2_q[0]};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d = 5'd0;
              if (pp_q)        state_d = S_WR_DATA;
              else if (quad_q) state_d = S_DUMMY;
              else             state_d = S_RD_DATA;
            end
          end
        end
        S_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d   = 5'd0;
              state_d = S_RD_DATA;
            end
          end
        end
        S_RD_DATA: begin
          // mem_rd_q tracks addr_q one clk behind; the post-increment fetch runs during the byte.
          if (fall) begin
            if (quad_q) begin
              io_oe_d = 4'b1111;
              if (!cnt_q[0]) begin
                out_io_d = mem_rd_q[7:4];
                tx_d     = {mem_rd_q[3:0], 4'h0};
                addr_d   = addr_q + ADDR_W'(1);
              end else begin
                out_io_d = tx_q[7:4];
              end
              cnt_d = {4'b0, ~cnt_q[0]};
            end else begin
              io_oe_d = 4'b0010;
              if (cnt_q[2:0] == 3'd0) begin
                out_io_d = {2'b0, mem_rd_q[7], 1'b0};
                tx_d     = {mem_rd_q[6:0], 1'b0};
                addr_d   = addr_q + ADDR_W'(1);
              end else begin
                out_io_d = {2'b0, tx_q[7], 1'b0};
                tx_d     = {tx_q[6:0], 1'b0};
              end
              cnt_d = {2'b0, cnt_q[2:0] + 3'd1};
            end
          end
        end
        S_WR_DATA: begin
          if (rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d  = 5'd0;
              wr_en  = 1'b1;
              addr_d = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_W'(1)) & PAGE_MASK);
            end
          end
        end
        S_STATUS: begin
          if (fall) begin
            io_oe_d  = 4'b0010;
            out_io_d = {2'b0, tx_q[7], 1'b0};
            tx_d     = {tx_q[6:0], tx_q[7]};
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_s3_q    <= 1'b1;
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      io_s1_q    <= 4'h0;
      io_s2_q    <= 4'h0;
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      sh_q       <= 8'h00;
      tx_q       <= 8'h00;
      addr_q     <= '0;
      wel_q      <= 1'b0;
      last_cmd_q <= 8'h00;
      out_io_q   <= 4'h0;
      io_oe_q    <= 4'h0;
      pp_q       <= 1'b0;
      quad_q     <= 1'b0;
    end else begin
      cs_s1_q    <= cs_n;
      cs_s2_q    <= cs_s1_q;
      cs_s3_q    <= cs_s2_q;
      sclk_s1_q  <= sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      io_s1_q    <= in_io;
      io_s2_q    <= io_s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      wel_q      <= wel_d;
      last_cmd_q <= last_cmd_d;
      out_io_q   <= out_io_d;
      io_oe_q    <= io_oe_d;
      pp_q       <= pp_d;
      quad_q     <= quad_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr_q] <= rx_byte;
    mem_rd_q <= mem_q[addr_q];
  end

  assign out_io   = out_io_q;
  assign io_oe    = io_oe_q;
  assign wel      = wel_q;
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_mem_flash_responder.sv
// Scoreboard bench for mem_flash_responder: an SPI master drives transactions, a monitor collects IO bytes.
`timescale 1ns/1ps
module tb_mem_flash_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic [3:0] in_io = 4'h0;
  logic [3:0] out_io, io_oe;
  logic       wel;
  logic [7:0] last_cmd;

  mem_flash_responder #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .in_io(in_io),
    .out_io(out_io), .io_oe(io_oe), .wel(wel), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] oe;
    bit         dc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem_m [1024];
  bit         known_m [1024];
  bit         wel_m = 1'b0;
  logic [7:0] last_m = 8'h00;
  logic [3:0] oe_at_rise;
  logic [3:0] oe_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: assembles bytes whenever the responder drives, compares against the queue.
  initial begin : monitor
    logic [7:0] acc;
    logic [3:0] oe_seen;
    int         nb;
    exp_t       e;
    acc = 8'h00; oe_seen = 4'h0; nb = 0;
    forever begin
      @(posedge sclk or posedge cs_n);
      if (cs_n) nb = 0;
      else if (io_oe != 4'h0) begin
        if (io_oe == 4'b1111) begin
          acc = {acc[3:0], out_io};
          nb += 4;
        end else begin
          acc = {acc[6:0], out_io[1]};
          nb += 1;
        end
        oe_seen = io_oe;
        if (nb >= 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none", acc);
          end else begin
            e = exp_q.pop_front();
            if (!e.dc) begin
              check("rd_byte", {24'h0, acc}, {24'h0, e.dat});
              check("rd_oe", {28'h0, oe_seen}, {28'h0, e.oe});
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic [3:0] oe, input bit dc);
    exp_t e;
    e.dat = d; e.oe = oe; e.dc = dc;
    exp_q.push_back(e);
  endtask

  task automatic sclk_bit(input logic [3:0] io);
    in_io = io;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    oe_at_rise = io_oe;
    oe_acc = oe_acc | io_oe;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sclk_bit({3'b0, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) sclk_bit({3'b0, a[i]});
  endtask

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) sclk_bit(4'h0);
  endtask

  task automatic t_simple(input logic [7:0] op);
    cs_start(); send_byte(op); clocks(4); cs_end();
    last_m = op;
    if (op == 8'h06) wel_m = 1'b1;
    if (op == 8'h04) wel_m = 1'b0;
  endtask

  task automatic t_pp(input logic [23:0] addr, input int n, input logic [31:0] d);
    int a;
    cs_start(); send_byte(8'h02); send_addr(addr);
    for (int i = 0; i < n; i++) send_byte(d[31-8*i -: 8]);
    cs_end();
    last_m = 8'h02;
    if (wel_m) begin
      for (int i = 0; i < n; i++) begin
        a = (int'(addr[9:0]) & 'h300) | ((int'(addr[9:0]) + i) & 'hFF);
        mem_m[a] = d[31-8*i -: 8];
        known_m[a] = 1'b1;
      end
    end
    wel_m = 1'b0;
  endtask

  task automatic t_read(input logic [23:0] addr, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (int'(addr[9:0]) + i) % 1024;
      push_exp(mem_m[a], 4'b0010, !known_m[a]);
    end
    cs_start(); send_byte(8'h03); send_addr(addr); clocks(8 * n); cs_end();
    last_m = 8'h03;
  endtask

  task automatic t_rdsr(input int n);
    for (int i = 0; i < n; i++) push_exp({6'b0, wel_m, 1'b0}, 4'b0010, 1'b0);
    cs_start(); send_byte(8'h05); clocks(8 * n); cs_end();
    last_m = 8'h05;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_wel"}, {31'h0, wel}, {31'h0, wel_m});
    check({tag, "_last_cmd"}, {24'h0, last_cmd}, {24'h0, last_m});
  endtask

  initial begin : main
    logic [23:0] ra;
    logic [23:0] last_pp;
    logic [7:0]  ops [4];
    int          op, n;
    for (int i = 0; i < 1024; i++) known_m[i] = 1'b0;
    oe_acc = 4'h0;
    last_pp = 24'h10;
    ops[0] = 8'h9F; ops[1] = 8'hAB; ops[2] = 8'h00; ops[3] = 8'hFF;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_out_io", {28'h0, out_io}, 32'h0);
    check("rst_io_oe", {28'h0, io_oe}, 32'h0);
    check("rst_wel", {31'h0, wel}, 32'h0);
    check("rst_last_cmd", {24'h0, last_cmd}, 32'h0);

    // cs pulse with no clocks leaves everything alone
    cs_start(); cs_end();
    check_state("cs_only");

    t_simple(8'h06);
    check_state("wren");
    t_pp(24'h000010, 2, 32'hA55A_0000);
    check_state("pp_a55a");
    t_read(24'h000010, 2);
    check_state("read_10");

    t_simple(8'h06);
    t_pp(24'h000020, 1, 32'h7700_0000);
    t_pp(24'h000020, 1, 32'h1100_0000);
    check_state("pp_no_wren");
    t_read(24'h000020, 1);

    t_simple(8'h06);
    t_pp(24'h0000FF, 2, 32'h0102_0000);
    t_read(24'h000000, 1);
    t_read(24'h0000FF, 1);
    t_simple(8'h06);
    t_pp(24'h0003FF, 1, 32'h3C00_0000);
    t_read(24'h0003FF, 2);

    // read aborted mid-byte, then status after WREN
    cs_start(); send_byte(8'h03); send_addr(24'h000010); clocks(4); cs_end();
    last_m = 8'h03;
    check("abort_io_oe", {28'h0, io_oe}, 32'h0);
    check("abort_out_io", {28'h0, out_io}, 32'h0);
    t_simple(8'h06);
    t_rdsr(2);
    check_state("rdsr_wel1");

    // quad output fast read
    oe_acc = 4'h0;
`ifdef FLASH_MODEL_QUAD_EN
    push_exp(8'hA5, 4'b1111, 1'b0);
    push_exp(8'h5A, 4'b1111, 1'b0);
    cs_start(); send_byte(8'h6B); send_addr(24'h000010);
    clocks(8);
    check("dummy_io_oe", {28'h0, oe_acc}, 32'h0);
    clocks(4); cs_end();
`else
    cs_start(); send_byte(8'h6B); send_addr(24'h000010); clocks(24); cs_end();
    check("quad_off_io_oe", {28'h0, oe_acc}, 32'h0);
`endif
    last_m = 8'h6B;
    check_state("quad");

    // reset during RD_DATA
    cs_start(); send_byte(8'h03); send_addr(24'h000010); clocks(3);
    check("pre_rst_io_oe", {28'h0, io_oe}, 32'h2);
    rst_n = 1'b0;
    cs_n = 1'b1;
    @(negedge clk);
    check("midrst_out_io", {28'h0, out_io}, 32'h0);
    check("midrst_io_oe", {28'h0, io_oe}, 32'h0);
    check("midrst_wel", {31'h0, wel}, 32'h0);
    wel_m = 1'b0;
    last_m = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_state("post_rst");
    t_rdsr(1);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: t_simple(8'h06);
        1: t_simple(8'h04);
        2: begin
          ra = {14'h0, 10'($urandom_range(0, 1023))};
          n = $urandom_range(1, 4);
          if ($urandom_range(0, 2) != 0) t_simple(8'h06);
          t_pp(ra, n, $urandom);
          last_pp = ra;
        end
        3: begin
          ra = ($urandom_range(0, 1) != 0) ? last_pp : {14'h0, 10'($urandom_range(0, 1023))};
          t_read(ra, $urandom_range(1, 4));
        end
        4: t_rdsr($urandom_range(1, 2));
        default: t_simple(ops[$urandom_range(0, 3)]);
      endcase
      check_state("rand");
    end

    repeat (10) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
